frame_capture: RTL and testbench
================================

// Module: frame_capture
// PURPOSE
//  Write side of the 320x240 RGB565 frame buffer that the VGA scan-out reads.
//  - Accepts a byte-serial camera stream: high byte first, then low byte, one byte per strobe.
//  - Pairs the bytes into 16-bit pixels and writes them at linear addresses 0..76799.
//  - Signals frame completion so recognition logic can run on a stable image.
// PARAMETERS
//  H_PIXELS  320  pixels stored per line; extra bytes in a line are dropped
//  V_LINES   240  lines stored per frame; extra lines are dropped
//  ADDR_W    17   frame buffer address width
// PORTS
//  clk25        in   1       system clock; all logic on its rising edge
//  rst          in   1       synchronous, active-high reset
//  cap_start    in   1       1-cycle pulse: arm a single-frame capture
//  cap_cont     in   1       level: 1 = re-arm automatically after each frame
//  cam_vsync    in   1       frame sync, high between frames, already synchronised to clk25
//  cam_href     in   1       line valid, high while a line's bytes arrive
//  cam_byte_vld in   1       1-cycle strobe: cam_data is valid this cycle
//  cam_data     in   8       camera byte
//  frame_we     out  1       frame buffer write enable, 1 cycle per pixel
//  frame_addr   out  ADDR_W  write address, row*H_PIXELS+col
//  frame_din    out  16      RGB565 write data
//  frame_done   out  1       1-cycle pulse at the end of a captured frame
//  busy         out  1       high in ARMED and CAPTURE
// BEHAVIOUR
//  Reset
//  - All outputs reset to 0.
//  - State = IDLE; byte phase, column, line and address counters = 0.
//  - Reset asserted mid-frame abandons the frame. No frame_done is issued.
//  Edge detect
//  - vs_q <= cam_vsync and hr_q <= cam_href every cycle.
//  - vs_fall = vs_q & ~cam_vsync; vs_rise = ~vs_q & cam_vsync; hr_fall = hr_q & ~cam_href.
//  State machine
//  - IDLE: go to ARMED on cap_start, or when cap_cont=1.
//  - ARMED: wait for vs_fall, then clear counters and go to CAPTURE. A frame already in progress is never captured partially.
//  - CAPTURE: on vs_rise, pulse frame_done. Next state is ARMED if cap_cont=1, else IDLE.
//  - cap_start while busy is ignored.
//  Byte pairing (CAPTURE only; byte accepted when cam_byte_vld & cam_href)
//  - Phase 0: latch hi <= cam_data, phase <= 1.
//  - Phase 1: pixel = {hi, cam_data}, phase <= 0.
//    - If col < H_PIXELS and line < V_LINES: register frame_we=1, frame_addr=addr, frame_din=pixel, then addr <= addr+1.
//    - col <= col+1, saturating at H_PIXELS.
//  - Latency: frame_we is high in the cycle after the low byte is accepted. frame_we is 0 in every other cycle.
//  - frame_addr and frame_din hold their last values while frame_we=0.
//  Line end (hr_fall)
//  - phase <= 0 (a dangling odd byte is discarded), col <= 0.
//  - If at least one byte was accepted in the line, line <= line+1, saturating at V_LINES.
//  Address rules
//  - addr never exceeds H_PIXELS*V_LINES-1; out-of-range pixels are not written.
//  - A short line leaves the unwritten columns at their old contents. The next line still starts at row*H_PIXELS (addr <= line*H_PIXELS on hr_fall).
//  Simultaneous events
//  - vs_rise and a pixel write in the same cycle: the write completes, then frame_done.
//  - hr_fall in the same cycle as an accepted byte: the byte is processed first, then line-end actions apply.
// CONFIGURATION
//  FRAME_CAPTURE_GRAY_EN
//  - Defined: frame_din carries grayscale replicated into RGB565. R5, G6, B5 are widened to 8 bits (R<<3, G<<2, B<<3).
//    - y = (77*R8 + 150*G8 + 29*B8) >> 8, 16-bit accumulator.
//    - frame_din = {y[7:3], y[7:2], y[7:3]}.
//    - Combinational on the pixel, so latency is unchanged.
//  - Undefined: frame_din = raw {hi, lo} pixel.
// TESTING
//  T1 reset: rst high for 3 cycles mid-CAPTURE -> outputs 0, busy=0, no frame_done, next frame not captured until cap_start.
//  T2 single frame: cap_start, vsync low, 240 lines x 640 bytes -> 76800 writes, addresses 0..76799 in order; vs_rise -> 1 frame_done; state IDLE.
//  T3 pairing: bytes 0xF8,0x00 at line 0 col 0 -> frame_we next cycle, addr 0, din 0xF800 (GRAY_EN: din 0x4A49).
//  T4 overrun: line of 700 bytes, 250 lines -> exactly 320 writes per line, last addr 76799, no write with addr >= 76800.
//  T5 odd/short line: line 5 has 7 bytes -> 3 writes at addr 1600..1602; line 6 starts at addr 1920.
//  T6 continuous: cap_cont=1, 2 frames -> 2 frame_done pulses, addr restarts at 0. cap_start pulsed mid-frame is ignored.

Source files
------------

// File: rtl/frame_capture.sv
// frame_capture: pairs byte-serial RGB565 camera bytes into pixels and writes one frame into the frame buffer.
// Ports: clk25/rst (sync, active-high); cap_start (arm one frame), cap_cont (auto re-arm);
// cam_vsync/cam_href/cam_byte_vld/cam_data (camera stream); frame_we/frame_addr/frame_din (buffer write);
// frame_done (end-of-frame pulse); busy (armed or capturing).
// Define FRAME_CAPTURE_GRAY_EN to store grayscale replicated into RGB565 instead of the raw pixel.
module frame_capture #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              cap_start,
  input  logic              cap_cont,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_byte_vld,
  input  logic [7:0]        cam_data,
  output logic              frame_we,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [15:0]       frame_din,
  output logic              frame_done,
  output logic              busy
);
  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [CW-1:0]     HP = CW'(H_PIXELS);
  localparam logic [LW-1:0]     VL = LW'(V_LINES);
  localparam logic [ADDR_W-1:0] HA = ADDR_W'(H_PIXELS);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
  state_t state, state_n;
  logic vs_q, hr_q, phase, seen;
  logic vs_fall, vs_rise, hr_fall, acc;
  logic [7:0] hi;
  logic [CW-1:0] col;
  logic [LW-1:0] line, line_n;
  logic [ADDR_W-1:0] addr;
  logic [15:0] pix_out;
  assign vs_fall = vs_q & ~cam_vsync;
  assign vs_rise = ~vs_q & cam_vsync;
  assign hr_fall = hr_q & ~cam_href;
  assign acc = (state == CAPTURE) & cam_byte_vld & cam_href;
  assign busy = state != IDLE;
  // A line only counts once it has carried at least one byte, including one accepted this cycle.
  assign line_n = ((seen | acc) && line < VL) ? line + 1'b1 : line;
`ifdef FRAME_CAPTURE_GRAY_EN
  logic [15:0] sum;
  logic [5:0] y6;
  assign sum = 16'd77  * {8'd0, hi[7:3], 3'd0}
             + 16'd150 * {8'd0, hi[2:0], cam_data[7:5], 2'd0}
             + 16'd29  * {8'd0, cam_data[4:0], 3'd0};
  // y6 is luma[7:2]; luma[7:3] is its top five bits.
  assign y6 = 6'(sum >> 10);
  assign pix_out = {y6[5:1], y6, y6[5:1]};
`else
  assign pix_out = {hi, cam_data};
`endif
  always_ff @(posedge clk25) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && (cap_start || cap_cont)) state_n = ARMED;
    if (state == ARMED && vs_fall) state_n = CAPTURE;
    if (state == CAPTURE && vs_rise) state_n = cap_cont ? ARMED : IDLE;
  end
  always_ff @(posedge clk25) begin
    if (rst) begin
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      phase      <= 1'b0;
      seen       <= 1'b0;
      hi         <= '0;
      col        <= '0;
      line       <= '0;
      addr       <= '0;
      frame_we   <= 1'b0;
      frame_addr <= '0;
      frame_din  <= '0;
      frame_done <= 1'b0;
    end else begin
      vs_q       <= cam_vsync;
      hr_q       <= cam_href;
      frame_we   <= 1'b0;
      frame_done <= (state == CAPTURE) & vs_rise;
      if (state == ARMED && vs_fall) begin
        phase <= 1'b0;
        seen  <= 1'b0;
        col   <= '0;
        line  <= '0;
        addr  <= '0;
      end
      if (acc) begin
        seen  <= 1'b1;
        phase <= ~phase;
        if (!phase) hi <= cam_data;
        else begin
          if (col < HP && line < VL) begin
            frame_we   <= 1'b1;
            frame_addr <= addr;
            frame_din  <= pix_out;
            addr       <= addr + 1'b1;
          end
          if (col < HP) col <= col + 1'b1;
        end
      end
      // Line end overrides the byte path: drop any odd byte and realign to the next row start.
      if (state == CAPTURE && hr_fall) begin
        phase <= 1'b0;
        seen  <= 1'b0;
        col   <= '0;
        line  <= line_n;
        addr  <= (line_n < VL) ? ADDR_W'(line_n) * HA : addr;
      end
    end
  end
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: scoreboard and vector bench for frame_capture on a reduced 16x8 frame.
module tb_frame_capture;
  localparam int H = 16, V = 8, AW = 17;
`ifdef FRAME_CAPTURE_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif
  logic clk25 = 1'b0, rst = 1'b1, cap_start = 1'b0, cap_cont = 1'b0;
  logic cam_vsync = 1'b1, cam_href = 1'b0, cam_byte_vld = 1'b0;
  logic [7:0] cam_data = '0;
  logic frame_we, frame_done, busy;
  logic [AW-1:0] frame_addr;
  logic [15:0] frame_din;
  typedef struct packed {logic [AW-1:0] a; logic [15:0] d;} wr_t;
  typedef struct {logic [7:0] hi; logic [7:0] lo; logic [15:0] raw; logic [15:0] gray;} vec_t;
  wr_t exp_q[$];
  wr_t e;
  vec_t tbl[5];
  int pass_cnt = 0, total = 0, done_cnt = 0, wr_cnt = 0;
  always #20 clk25 = ~clk25;
  frame_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk25(clk25), .rst(rst), .cap_start(cap_start), .cap_cont(cap_cont),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte_vld(cam_byte_vld), .cam_data(cam_data),
    .frame_we(frame_we), .frame_addr(frame_addr), .frame_din(frame_din),
    .frame_done(frame_done), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [15:0] model(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] y;
    y = (16'd77 * {8'd0, hi[7:3], 3'd0} + 16'd150 * {8'd0, hi[2:0], lo[7:5], 2'd0}
       + 16'd29 * {8'd0, lo[4:0], 3'd0}) >> 8;
    return GRAY ? {y[7:3], y[7:2], y[7:3]} : {hi, lo};
  endfunction
  task automatic tick;
    @(posedge clk25);
    #1;
  endtask
  task automatic pulse_start;
    cap_start = 1'b1;
    tick;
    cap_start = 1'b0;
  endtask
  always @(negedge clk25) begin
    if (frame_done) done_cnt++;
    if (frame_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr %0d din %h, no write expected", frame_addr, frame_din);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(frame_addr), 32'(e.a));
        chk("wr_din", 32'(frame_din), 32'(e.d));
      end
    end
  end
  task automatic send_line(input int n, input int ln, input bit cap);
    logic [7:0] hi, b;
    hi = '0;
    cam_href = 1'b1;
    tick;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      cam_byte_vld = 1'b1;
      cam_data = b;
      tick;
      cam_byte_vld = 1'b0;
      if (i % 2 == 0) hi = b;
      else if (cap && i / 2 < H && ln < V) exp_q.push_back({AW'(ln * H + i / 2), model(hi, b)});
    end
    cam_href = 1'b0;
    tick;
    tick;
  endtask
  task automatic run_frame(input int nl, input int nb, input int sl, input int sn, input bit cap, input bit ps);
    int ln, n;
    ln = 0;
    cam_vsync = 1'b0;
    tick;
    tick;
    for (int l = 0; l < nl; l++) begin
      n = (l == sl) ? sn : nb;
      send_line(n, ln, cap);
      if (ps && l == 1) pulse_start;
      if (n > 0 && ln < V) ln++;
    end
    cam_vsync = 1'b1;
    repeat (3) tick;
  endtask
  initial begin
    int d0, w0;
    tbl[0] = '{8'hF8, 8'h00, 16'hF800, 16'h4A49};
    tbl[1] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
    tbl[2] = '{8'hFF, 8'hFF, 16'hFFFF, 16'hFFDF};
    tbl[3] = '{8'h07, 8'hE0, 16'h07E0, 16'h9492};
    tbl[4] = '{8'h12, 8'h34, 16'h1234, 16'h39E7};
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("rst_we", 32'(frame_we), 0);
    chk("rst_addr", 32'(frame_addr), 0);
    chk("rst_din", 32'(frame_din), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    pulse_start;
    chk("armed_busy", 32'(busy), 1);
    cam_vsync = 1'b0;
    tick;
    tick;
    cam_href = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      cam_byte_vld = 1'b1;
      cam_data = tbl[i].hi;
      tick;
      if (i == 0) chk("we_after_hi", 32'(frame_we), 0);
      cam_data = tbl[i].lo;
      tick;
      cam_byte_vld = 1'b0;
      exp_q.push_back({AW'(i), GRAY ? tbl[i].gray : tbl[i].raw});
      if (i == 0) chk("we_after_lo", 32'(frame_we), 1);
    end
    tick;
    chk("we_idle", 32'(frame_we), 0);
    chk("din_hold", 32'(frame_din), 32'(GRAY ? tbl[4].gray : tbl[4].raw));
    cam_href = 1'b0;
    tick;
    cam_vsync = 1'b1;
    repeat (3) tick;
    chk("t3_done", done_cnt, 1);
    chk("t3_idle", 32'(busy), 0);
    chk("t3_q", exp_q.size(), 0);
    cam_vsync = 1'b0;
    tick;
    pulse_start;
    send_line(2 * H, 0, 1'b0);
    cam_vsync = 1'b1;
    repeat (3) tick;
    chk("partial_done", done_cnt, 1);
    w0 = wr_cnt;
    run_frame(V, 2 * H, -1, 0, 1'b1, 1'b0);
    chk("t2_writes", wr_cnt - w0, H * V);
    chk("t2_done", done_cnt, 2);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_q", exp_q.size(), 0);
    pulse_start;
    w0 = wr_cnt;
    run_frame(V + 2, 2 * H + 12, -1, 0, 1'b1, 1'b0);
    chk("t4_writes", wr_cnt - w0, H * V);
    chk("t4_last_addr", 32'(frame_addr), H * V - 1);
    chk("t4_done", done_cnt, 3);
    chk("t4_q", exp_q.size(), 0);
    pulse_start;
    w0 = wr_cnt;
    run_frame(V, 2 * H, 5, 7, 1'b1, 1'b0);
    chk("t5_writes", wr_cnt - w0, H * (V - 1) + 3);
    chk("t5_done", done_cnt, 4);
    chk("t5_q", exp_q.size(), 0);
    cap_cont = 1'b1;
    tick;
    run_frame(V, 2 * H, -1, 0, 1'b1, 1'b1);
    chk("t6_busy_rearm", 32'(busy), 1);
    run_frame(V, 2 * H, 3, 9, 1'b1, 1'b1);
    chk("t6_done", done_cnt, 6);
    chk("t6_q", exp_q.size(), 0);
    cap_cont = 1'b0;
    tick;
    chk("t6_still_armed", 32'(busy), 1);
    d0 = done_cnt;
    cam_vsync = 1'b0;
    tick;
    tick;
    cam_href = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      cam_byte_vld = 1'b1;
      cam_data = 8'(8'h30 + i);
      tick;
      cam_byte_vld = 1'b0;
      if (i % 2 == 1) exp_q.push_back({AW'(i / 2), model(8'(8'h30 + i - 1), 8'(8'h30 + i))});
    end
    tick;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    chk("t1_we", 32'(frame_we), 0);
    chk("t1_addr", 32'(frame_addr), 0);
    chk("t1_din", 32'(frame_din), 0);
    chk("t1_busy", 32'(busy), 0);
    cam_href = 1'b0;
    tick;
    cam_vsync = 1'b1;
    repeat (3) tick;
    chk("t1_no_done", done_cnt, d0);
    run_frame(2, 2 * H, -1, 0, 1'b0, 1'b0);
    chk("t1_not_captured", done_cnt, d0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_q", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
